// File: rtl/activation_unit.sv
// activation_unit
//   Per-column activation stage that follows the systolic accumulators.
//   Each lane takes one Q16.16 accumulator word and produces one saturated
//   8-bit result. The available functions are no activation, ReLU, and a
//   piecewise-linear sigmoid. All lanes share one mode and run in lock-step
//   through a two-stage pipeline.
//
//   Pipeline:
//     stage 1 : registers data_in together with its is_signed and
//               activation_function controls.
//     stage 2 : applies the activation to the stage-1 contents and
//               registers the result into data_out.
//   A vector applied before edge N is visible on data_out after edge N+1,
//   counting only edges where enable=1.
//
//   Activation codes (4 bit):
//     0 = no activation, 1 = relu, 9 = sigmoid.
//     Any other code behaves as no activation.
//
// Ports
//   clk                  in   rising-edge clock
//   rst                  in   synchronous active-high reset; overrides enable
//   enable               in   pipeline advance; when low, every register holds
//   activation_function  in   [3:0] activation code, sampled with data_in
//   is_signed            in   1: two's-complement in/out, 0: unsigned in/out
//   data_in              in   [MATRIX_WIDTH-1:0][31:0] Q16.16 lane inputs
//   data_out             out  [MATRIX_WIDTH-1:0][7:0] activated lane results
module activation_unit #(
  parameter int MATRIX_WIDTH = 14
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [3:0]                     activation_function,
  input  logic                           is_signed,
  input  logic [MATRIX_WIDTH-1:0][31:0]  data_in,
  output logic [MATRIX_WIDTH-1:0][7:0]   data_out
);

  localparam logic [3:0] ACT_NONE    = 4'd0;
  localparam logic [3:0] ACT_RELU    = 4'd1;
  localparam logic [3:0] ACT_SIGMOID = 4'd9;

  logic [MATRIX_WIDTH-1:0][31:0] data_q;
  logic                          signed_q;
  logic [3:0]                    func_q;
  logic [MATRIX_WIDTH-1:0][7:0]  data_out_d;
  logic [MATRIX_WIDTH-1:0][7:0]  data_out_q;

  // One lane of the activation datapath. The input is widened to 34 bits.
  // This lets unsigned words near 0xFFFF_FFFF take the +0.5 rounding offset
  // without wrapping negative, so they saturate as expected.
  function automatic logic [7:0] activate(input logic [31:0] word,
                                          input logic        sgn,
                                          input logic [3:0]  func);
    logic signed [33:0] x;
    logic signed [33:0] rnd;
    logic signed [17:0] r;
    logic signed [24:0] x8;
    logic        [24:0] a;
    logic        [8:0]  t;
    logic        [8:0]  y;
    logic        [7:0]  res;

    x   = sgn ? {{2{word[31]}}, word} : {2'b00, word};
    rnd = x + 34'sd32768;
    r   = 18'(rnd >>> 16);
    x8  = 25'(x >>> 8);
    a   = x8[24] ? 25'(-x8) : 25'(x8);

    // Piecewise-linear table value, expressed in 1/256 units.
    if (a < 25'd256)       t = 9'(a >> 2) + 9'd128;
    else if (a < 25'd608)  t = 9'(a >> 3) + 9'd160;
    else if (a < 25'd1280) t = 9'(a >> 5) + 9'd216;
    else                   t = 9'd256;

    // The sigmoid is point-symmetric around 0.5.
    y = x8[24] ? (9'd256 - t) : t;

    res = 8'd0;
    if (func == ACT_SIGMOID) begin
      if (sgn) res = ((y >> 1) > 9'd127) ? 8'd127 : 8'(y >> 1);
      else     res = (y > 9'd255)        ? 8'd255 : 8'(y);
    end else if (func == ACT_RELU) begin
      if (sgn) begin
        if (r <= 18'sd0)        res = 8'd0;
        else if (r > 18'sd127)  res = 8'd127;
        else                    res = r[7:0];
      end else begin
        res = (r > 18'sd255) ? 8'd255 : r[7:0];
      end
    end else begin
      if (sgn) begin
        if (r > 18'sd127)       res = 8'd127;
        else if (r < -18'sd128) res = 8'h80;
        else                    res = r[7:0];
      end else begin
        if (r > 18'sd255)       res = 8'd255;
        else if (r < 18'sd0)    res = 8'd0;
        else                    res = r[7:0];
      end
    end
    return res;
  endfunction

  // Stage 1 captures the operands and the mode that goes with them.
  // Because the mode is registered per vector, it can change on every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      signed_q <= 1'b0;
      func_q   <= ACT_NONE;
    end else if (enable) begin
      data_q   <= data_in;
      signed_q <= is_signed;
      func_q   <= activation_function;
    end
  end

  // Stage 2 applies the activation to every lane in parallel.
  always_comb begin
    data_out_d = '0;
    for (int i = 0; i < MATRIX_WIDTH; i++) begin
      data_out_d[i] = activate(data_q[i], signed_q, func_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
    end else if (enable) begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_activation_unit.sv
// tb_activation_unit
//   Scoreboard bench for activation_unit. The driver issues one vector on
//   every enabled cycle and pushes the expected result, taken from an
//   arithmetic reference model, into a queue. It also records the enabled
//   edge at which stage 1 captures that vector.
//   The monitor advances its own count of enabled edges. It pops each entry
//   once the entry's output edge arrives. It also checks that reset clears
//   the output and that enable=0 freezes it.
module tb_activation_unit;

  localparam int MW = 14;
  localparam logic [3:0] F_NONE = 4'd0;
  localparam logic [3:0] F_RELU = 4'd1;
  localparam logic [3:0] F_SIG  = 4'd9;

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic [3:0]           activation_function;
  logic                 is_signed;
  logic [MW-1:0][31:0]  data_in;
  logic [MW-1:0][7:0]   data_out;

  typedef struct {
    logic [MW-1:0][7:0] exp;
    longint             capEdge;
  } item_t;

  typedef struct {
    logic [31:0] w;
    logic        s;
    logic [3:0]  f;
    logic [7:0]  e;
  } dir_t;

  item_t  sbQ[$];
  dir_t   dirTab[$];
  longint edgeCount    = 0;
  int     compareCount = 0;
  int     failCount    = 0;
  int     popCount     = 0;

  activation_unit #(.MATRIX_WIDTH(MW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .activation_function (activation_function),
    .is_signed           (is_signed),
    .data_in             (data_in),
    .data_out            (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model. It works on plain 64-bit integers and follows the
  // activation rules directly.
  function automatic logic [7:0] refAct(input logic [31:0] d, input logic sgn,
                                        input logic [3:0] fn);
    longint x, r, x8, a, t, y, lo, hi;
    x = sgn ? longint'($signed(d)) : longint'({32'b0, d});
    r = (x + 32768) >>> 16;
    if (fn == F_SIG) begin
      x8 = x >>> 8;
      a  = (x8 < 0) ? -x8 : x8;
      if (a < 256)       t = a / 4 + 128;
      else if (a < 608)  t = a / 8 + 160;
      else if (a < 1280) t = a / 32 + 216;
      else               t = 256;
      y = (x8 >= 0) ? t : 256 - t;
      if (sgn) return 8'((y / 2 > 127) ? 127 : y / 2);
      return 8'((y > 255) ? 255 : y);
    end
    if (fn == F_RELU) begin
      lo = 0;
      hi = sgn ? 127 : 255;
    end else begin
      lo = sgn ? -128 : 0;
      hi = sgn ? 127 : 255;
    end
    if (r < lo) r = lo;
    if (r > hi) r = hi;
    return 8'(r);
  endfunction

  function automatic logic [31:0] randWord();
    int v;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: begin
        v = int'($urandom_range(0, 2097152)) - 1048576;
        return 32'(v);
      end
      2: begin
        v = int'($urandom_range(0, 33554432)) - 16777216;
        return 32'(v);
      end
      default: begin
        case ($urandom_range(0, 7))
          0: return 32'h8000_0000;
          1: return 32'h7FFF_FFFF;
          2: return 32'hFFFF_FFFF;
          3: return 32'h0000_0000;
          4: return 32'h0000_8000;
          5: return 32'hFFFF_8000;
          6: return 32'h007F_8000;
          default: return 32'h00FF_7FFF;
        endcase
      end
    endcase
  endfunction

  function automatic logic [3:0] randFunc();
    case ($urandom_range(0, 3))
      0: return F_NONE;
      1: return F_RELU;
      2: return F_SIG;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  // Drives one cycle at the falling edge. On an enabled, non-reset cycle the
  // expected output is queued. Lane 0 can optionally carry a fixed expected
  // value instead of the model's.
  task automatic applyStimulus(input logic [MW-1:0][31:0] d, input logic sgn,
                               input logic [3:0] fn, input logic en,
                               input logic rs, input bit useFixed,
                               input logic [7:0] fixedExp);
    item_t it;
    @(negedge clk);
    data_in             = d;
    is_signed           = sgn;
    activation_function = fn;
    enable              = en;
    rst                 = rs;
    if (en && !rs) begin
      for (int i = 0; i < MW; i++) it.exp[i] = refAct(d[i], sgn, fn);
      if (useFixed) it.exp[0] = fixedExp;
      it.capEdge = edgeCount + 1;
      sbQ.push_back(it);
    end
  endtask

  task automatic applyRandom(input logic en, input logic rs);
    logic [MW-1:0][31:0] d;
    for (int i = 0; i < MW; i++) d[i] = randWord();
    applyStimulus(d, 1'($urandom_range(0, 1)), randFunc(), en, rs, 1'b0, 8'd0);
  endtask

  task automatic checkOutput(input string name, input logic [MW-1:0][7:0] act,
                             input logic [MW-1:0][7:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s @%0t: data_out=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: track enabled edges and compare after each edge settles.
  // The edge right after a reset shows the cleared stage-1 contents, which
  // produce zero in no-activation unsigned mode.
  logic [MW-1:0][7:0] expOut;
  always begin
    logic  sRst, sEn;
    item_t it;
    @(posedge clk);
    sRst = rst;
    sEn  = enable;
    if (!sRst && sEn) edgeCount++;
    #1;
    if (sRst) begin
      sbQ.delete();
      expOut = '0;
      checkOutput("reset", data_out, expOut);
    end else if (!sEn) begin
      checkOutput("freeze", data_out, expOut);
    end else begin
      if (sbQ.size() > 0 && sbQ[0].capEdge + 1 <= edgeCount) begin
        it     = sbQ.pop_front();
        expOut = it.exp;
        popCount++;
        checkOutput((it.capEdge + 1 == edgeCount) ? "pipe" : "pipe_late",
                    data_out, expOut);
      end else begin
        expOut = '0;
        checkOutput("post_reset", data_out, expOut);
      end
    end
  end

  initial begin
    logic [MW-1:0][31:0] d;
    rst                 = 1'b1;
    enable              = 1'b1;
    is_signed           = 1'b1;
    activation_function = F_SIG;
    data_in             = '1;

    dirTab.push_back('{32'h8000_0000, 1'b1, F_SIG,  8'd0});
    dirTab.push_back('{32'h7FFF_FFFF, 1'b1, F_SIG,  8'd127});
    dirTab.push_back('{32'hFFFA_0000, 1'b1, F_SIG,  8'd0});
    dirTab.push_back('{32'h0006_0000, 1'b1, F_SIG,  8'd127});
    dirTab.push_back('{32'h0000_0000, 1'b1, F_SIG,  8'd64});
    dirTab.push_back('{32'h0001_0000, 1'b1, F_SIG,  8'd96});
    dirTab.push_back('{32'hFFFF_0000, 1'b1, F_SIG,  8'd32});
    dirTab.push_back('{32'h0000_0000, 1'b0, F_SIG,  8'd128});
    dirTab.push_back('{32'h0002_8000, 1'b0, F_SIG,  8'd236});
    dirTab.push_back('{32'h0007_0000, 1'b0, F_SIG,  8'd255});
    dirTab.push_back('{32'hFFFF_FFFF, 1'b0, F_SIG,  8'd255});
    dirTab.push_back('{32'hFFFF_8000, 1'b1, F_RELU, 8'd0});
    dirTab.push_back('{32'h0000_8000, 1'b1, F_RELU, 8'd1});
    dirTab.push_back('{32'h0000_7F00, 1'b1, F_RELU, 8'd0});
    dirTab.push_back('{32'h007F_8000, 1'b1, F_RELU, 8'd127});
    dirTab.push_back('{32'hFF80_0000, 1'b1, F_RELU, 8'd0});
    dirTab.push_back('{32'h0012_8000, 1'b0, F_RELU, 8'd19});
    dirTab.push_back('{32'h00FF_7FFF, 1'b0, F_RELU, 8'd255});
    dirTab.push_back('{32'h0100_0000, 1'b0, F_RELU, 8'd255});
    dirTab.push_back('{32'hFF80_0000, 1'b1, F_NONE, 8'h80});
    dirTab.push_back('{32'h0080_0000, 1'b1, F_NONE, 8'd127});
    dirTab.push_back('{32'h0012_8000, 1'b0, 4'd5,   8'd19});
    dirTab.push_back('{32'h0300_0000, 1'b0, 4'd5,   8'd255});

    // Reset with enable high, then the directed cases back to back.
    applyRandom(1'b1, 1'b1);
    applyRandom(1'b1, 1'b1);
    foreach (dirTab[k]) begin
      for (int i = 0; i < MW; i++) d[i] = randWord();
      d[0] = dirTab[k].w;
      applyStimulus(d, dirTab[k].s, dirTab[k].f, 1'b1, 1'b0, 1'b1, dirTab[k].e);
    end

    // Hold the pipeline for three cycles, then resume.
    for (int n = 0; n < 3; n++) applyRandom(1'b0, 1'b0);
    for (int n = 0; n < 6; n++) applyRandom(1'b1, 1'b0);

    // Reset in the middle of a stream discards the in-flight vectors.
    applyRandom(1'b1, 1'b1);
    for (int n = 0; n < 6; n++) applyRandom(1'b1, 1'b0);

    // Random traffic with occasional stalls and rare resets.
    for (int n = 0; n < 400; n++) begin
      applyRandom(1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 99) < 2));
    end
    for (int n = 0; n < 3; n++) applyRandom(1'b1, 1'b0);
    @(negedge clk);

    if (popCount == 0) begin
      failCount++;
      $display("[TB] FAIL no_outputs: popped=%0d required>0", popCount);
    end
    $display("== %0d vectors applied, %0d miscompares ==", compareCount, failCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: time=%0t limit=2000000", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
